// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port (we3/ad3/wd3) between the
// execute writeback (src0) and the load/long-latency writeback (src1), and
// keeps a pending-write scoreboard (busy) for RAW hazard stalls at issue.
//
// Build option:
//   RF_ARB_RR_EN defined   -> round-robin arbitration. After a contested grant
//                             the priority pointer moves to the loser.
//   RF_ARB_RR_EN undefined -> fixed priority. src0 always wins and there is
//                             no pointer register.
//
// The write stage drains every cycle, so an uncontested request is always
// accepted. Ready depends only on the valid inputs and the pointer, never on
// the addresses. A write to x0 is accepted but does not assert we3.

module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s0_valid,
    input  logic [ADDR_WIDTH-1:0]    s0_addr,
    input  logic [DATA_WIDTH-1:0]    s0_data,
    output logic                     s0_ready,
    input  logic                     s1_valid,
    input  logic [ADDR_WIDTH-1:0]    s1_addr,
    input  logic [DATA_WIDTH-1:0]    s1_data,
    output logic                     s1_ready,
    input  logic                     rsv_valid,
    input  logic [ADDR_WIDTH-1:0]    rsv_addr,
    output logic                     we3,
    output logic [ADDR_WIDTH-1:0]    ad3,
    output logic [DATA_WIDTH-1:0]    wd3,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic                  gnt0;
    logic                  gnt1;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  wr_next;
    logic [NREGS-1:0]      busy_next;

`ifdef RF_ARB_RR_EN
    // 0 -> src0 has priority on contention, 1 -> src1 has priority.
    logic ptr;
`endif

    // Grant: a lone requester wins; on contention the priority source wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (s0_valid && s1_valid) begin
`ifdef RF_ARB_RR_EN
                gnt0 = ~ptr;
                gnt1 = ptr;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = s0_valid;
                gnt1 = s1_valid;
            end
        end
    end

    assign s0_ready = gnt0;
    assign s1_ready = gnt1;

    // Winner's write, suppressed for x0 (still accepted, never written).
    always_comb begin
        win_addr = gnt1 ? s1_addr : s0_addr;
        win_data = gnt1 ? s1_data : s0_data;
        wr_next  = (gnt0 || gnt1) && (win_addr != '0);
    end

    // Scoreboard update: retiring write clears, reservation sets, set wins.
    always_comb begin
        busy_next = busy;
        if (we3) begin
            busy_next[ad3] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Registered write port and scoreboard; ad3/wd3 hold when nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3  <= 1'b0;
            ad3  <= '0;
            wd3  <= '0;
            busy <= '0;
        end else begin
            we3  <= wr_next;
            busy <= busy_next;
            if (wr_next) begin
                ad3 <= win_addr;
                wd3 <= win_data;
            end
        end
    end

`ifdef RF_ARB_RR_EN
    // Priority pointer moves to the losing source after each contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (s0_valid && s1_valid) begin
            ptr <= ~ptr;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed tests followed by random traffic,
// all checked against a transaction-level reference model.
`timescale 1ns/1ps

module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_valid, s1_valid, rsv_valid;
    logic [AW-1:0] s0_addr, s1_addr, rsv_addr;
    logic [DW-1:0] s0_data, s1_data;
    logic          s0_ready, s1_ready;
    logic          we3;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;
    logic [31:0]   busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_we;
    logic [4:0]  m_ad;
    logic [31:0] m_wd;
    logic [31:0] m_busy;
    int          m_turn;      // which source is favoured on contention
    bit          last_g0, last_g1;
`ifdef RF_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .we3(we3), .ad3(ad3), .wd3(wd3), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v0, input int a0, input logic [31:0] d0,
                         input bit v1, input int a1, input logic [31:0] d1,
                         input bit rv, input int ra);
        rst = r;
        s0_valid = v0; s0_addr = 5'(a0); s0_data = d0;
        s1_valid = v1; s1_addr = 5'(a1); s1_data = d1;
        rsv_valid = rv; rsv_addr = 5'(ra);
    endtask

    // One cycle: inputs already driven (#1 after an edge). Check ready against
    // the model, advance the model, cross the edge and check the registered outputs.
    task automatic tick(input string tag);
        bit g0, g1, xfer;
        int waddr;
        logic [31:0] wdata, nb;
        #1;
        g0 = 0; g1 = 0;
        if (!rst) begin
            if (s0_valid && s1_valid) begin
                if (RR && m_turn == 1) g1 = 1; else g0 = 1;
            end else begin
                g0 = s0_valid;
                g1 = s1_valid;
            end
        end
        chk({tag, ".s0_ready"}, 32'(s0_ready), 32'(g0));
        chk({tag, ".s1_ready"}, 32'(s1_ready), 32'(g1));
        last_g0 = g0; last_g1 = g1;

        if (rst) begin
            m_we = 0; m_ad = 0; m_wd = 0; m_busy = 0; m_turn = 0;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_ad] = 1'b0;
            if (rsv_valid && rsv_addr != 0) nb[rsv_addr] = 1'b1;
            nb[0] = 1'b0;
            m_busy = nb;
            xfer  = g0 || g1;
            waddr = g1 ? int'(s1_addr) : int'(s0_addr);
            wdata = g1 ? s1_data : s0_data;
            m_we  = xfer && waddr != 0;
            if (m_we) begin
                m_ad = 5'(waddr);
                m_wd = wdata;
            end
            if (RR && s0_valid && s1_valid) m_turn = g0 ? 1 : 0;
        end

        @(posedge clk); #1;
        chk({tag, ".we3"},  32'(we3), 32'(m_we));
        if (m_we) begin
            chk({tag, ".ad3"}, 32'(ad3), 32'(m_ad));
            chk({tag, ".wd3"}, wd3, m_wd);
        end
        chk({tag, ".busy"}, busy, m_busy);
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(tag);
    endtask

    initial begin
        bit p0, p1;
        int a0, a1;
        logic [31:0] d0, d1;

        // Bring the DUT to a known state before any checking.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        m_we = 0; m_ad = 0; m_wd = 0; m_busy = 0; m_turn = 0;

        // T1: reset held with both sources requesting
        drive(1, 1, 3, 32'h1111_1111, 1, 4, 32'h2222_2222, 1, 6);
        tick("t1_rst0");
        tick("t1_rst1");
        chk("t1_we3_after_rst", 32'(we3), 32'd0);
        chk("t1_busy_after_rst", busy, 32'd0);

        // T2: single write from src0
        drive(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        tick("t2_write");
        chk("t2_ad3", 32'(ad3), 32'd5);
        chk("t2_wd3", wd3, 32'hDEAD_BEEF);
        idle("t2_drain");
        chk("t2_we3_low", 32'(we3), 32'd0);

        // T3: contention for 3 cycles from a freshly reset pointer
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("t3_rst");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 32'hA000_0000 + 32'(i), 1, 2, 32'hB000_0000 + 32'(i), 0, 0);
            tick($sformatf("t3_c%0d", i));
            chk($sformatf("t3_ad3_%0d", i), 32'(ad3),
                (RR && i == 1) ? 32'd2 : 32'd1);
        end
        idle("t3_drain");

        // T4: write to x0 is accepted but dropped
        drive(0, 0, 0, 0, 1, 0, 32'h0000_1234, 0, 0);
        tick("t4_x0");
        chk("t4_s1_ready", 32'(last_g1), 32'd1);
        chk("t4_we3_low", 32'(we3), 32'd0);
        chk("t4_busy", busy, 32'd0);

        // T5: scoreboard set, clear, and set-wins-over-clear
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
        tick("t5_rsv");
        chk("t5_busy7_set", 32'(busy[7]), 32'd1);
        drive(0, 0, 0, 0, 1, 7, 32'h7777_0001, 0, 0);
        tick("t5_wr");
        idle("t5_clr");
        chk("t5_busy7_clr", 32'(busy[7]), 32'd0);
        drive(0, 0, 0, 0, 1, 7, 32'h7777_0002, 0, 0);
        tick("t5_wr2");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
        tick("t5_setwins");
        chk("t5_busy7_held", 32'(busy[7]), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("t5_rsv_x0");
        chk("t5_busy0", 32'(busy[0]), 32'd0);

        // T6: reset lands on the cycle a write to x9 is offered
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
        tick("t6_rsv");
        chk("t6_busy9_set", 32'(busy[9]), 32'd1);
        drive(1, 1, 9, 32'h9999_9999, 0, 0, 0, 0, 0);
        tick("t6_rst");
        chk("t6_we3_low", 32'(we3), 32'd0);
        chk("t6_busy9_clr", 32'(busy[9]), 32'd0);

        // Random traffic; a losing source holds its request until accepted.
        p0 = 0; p1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; a0 = int'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; a1 = int'($urandom_range(0, 31)); d1 = $urandom;
            end
            drive(($urandom_range(0, 39) == 0), p0, a0, d0, p1, a1, d1,
                  ($urandom_range(0, 1) == 1), int'($urandom_range(0, 31)));
            tick($sformatf("rnd%0d", c));
            if (last_g0) p0 = 0;
            if (last_g1) p1 = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
